// File: rtl/ysyx_24110006_lsu_if.sv
// Bundle of the EXU-side handshake, the word-aligned memory bus and the
// write-back handshake seen by the load/store unit.
interface ysyx_24110006_lsu_if;
  logic        i_valid;
  logic        o_ready;
  logic        i_wen;
  logic [2:0]  i_func;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [1:0]  o_err_code;

  // LSU side
  modport master (
    input  i_valid, i_wen, i_func, i_addr, i_wdata, i_mem_ack, i_mem_rdata, i_ready,
    output o_ready, o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
           o_valid, o_rdata, o_err, o_err_code
  );

  // EXU / memory / write-back side
  modport slave (
    output i_valid, i_wen, i_func, i_addr, i_wdata, i_mem_ack, i_mem_rdata, i_ready,
    input  o_ready, o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
           o_valid, o_rdata, o_err, o_err_code
  );
endinterface

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: one operation at a time, word-aligned req/ack bus, load
// alignment and extension, and a bus-wait timeout that reports an error.
module ysyx_24110006_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  ysyx_24110006_lsu_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic        wen_r;
  logic [2:0]  func_r;
  logic [1:0]  off_r;
  logic        ready_r;
  logic        mem_req_r;
  logic        mem_wen_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_wmask_r;
  logic        valid_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic [1:0]  err_code_r;

  logic        func_ok_s;
  logic        size_bad_s;
  logic        accept_err_s;
  logic [3:0]  st_wmask_s;
  logic [31:0] st_wdata_s;

  // Select the addressed byte/half of the bus word and extend it per funct3.
  function automatic logic [31:0] load_extract(input logic [2:0] func,
                                               input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (func)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Legality and alignment of the operation offered by the EXU.
  always_comb begin
    func_ok_s  = 1'b0;
    size_bad_s = 1'b0;
    if (bus.i_wen) begin
      func_ok_s = (bus.i_func <= 3'b010);
    end else begin
      case (bus.i_func)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: func_ok_s = 1'b1;
        default:                                 func_ok_s = 1'b0;
      endcase
    end
    case (bus.i_func[1:0])
      2'b01:   size_bad_s = bus.i_addr[0];
      2'b10:   size_bad_s = |bus.i_addr[1:0];
      default: size_bad_s = 1'b0;
    endcase
    accept_err_s = ~func_ok_s | size_bad_s;
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    st_wmask_s = 4'b1111;
    st_wdata_s = bus.i_wdata;
    case (bus.i_func[1:0])
      2'b00: begin
        st_wmask_s = 4'b0001 << bus.i_addr[1:0];
        st_wdata_s = {4{bus.i_wdata[7:0]}};
      end
      2'b01: begin
        st_wmask_s = bus.i_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata_s = {2{bus.i_wdata[15:0]}};
      end
      default: begin
        st_wmask_s = 4'b1111;
        st_wdata_s = bus.i_wdata;
      end
    endcase
  end

  // Control FSM; every output is a register so no input reaches an output combinationally.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'h0000;
      wen_r       <= 1'b0;
      func_r      <= 3'b000;
      off_r       <= 2'b00;
      ready_r     <= 1'b1;
      mem_req_r   <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_wmask_r <= 4'b0000;
      valid_r     <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
      err_code_r  <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_valid) begin
            wen_r   <= bus.i_wen;
            func_r  <= bus.i_func;
            off_r   <= bus.i_addr[1:0];
            ready_r <= 1'b0;
            if (accept_err_s) begin
              state_r    <= ST_RESP;
              valid_r    <= 1'b1;
              rdata_r    <= 32'h0000_0000;
              err_r      <= 1'b1;
              err_code_r <= 2'b01;
            end else begin
              state_r     <= ST_REQ;
              cnt_r       <= 16'h0000;
              mem_req_r   <= 1'b1;
              mem_wen_r   <= bus.i_wen;
              mem_addr_r  <= {bus.i_addr[31:2], 2'b00};
              mem_wdata_r <= bus.i_wen ? st_wdata_s : 32'h0000_0000;
              mem_wmask_r <= bus.i_wen ? st_wmask_s : 4'b0000;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_REQ: begin
          // An ack in the final wait cycle takes priority over the timeout.
          if (bus.i_mem_ack || (cnt_r == WAIT_LAST)) begin
            state_r     <= ST_RESP;
            mem_req_r   <= 1'b0;
            mem_wen_r   <= 1'b0;
            mem_wdata_r <= 32'h0000_0000;
            mem_wmask_r <= 4'b0000;
            valid_r     <= 1'b1;
            if (bus.i_mem_ack) begin
              rdata_r    <= wen_r ? 32'h0000_0000 : load_extract(func_r, off_r, bus.i_mem_rdata);
              err_r      <= 1'b0;
              err_code_r <= 2'b00;
            end else begin
              rdata_r    <= 32'h0000_0000;
              err_r      <= 1'b1;
              err_code_r <= 2'b10;
            end
          end else begin
            cnt_r <= cnt_r + 16'h0001;
          end
        end
        ST_RESP: begin
          if (bus.i_ready) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 16'h0000;
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= 16'h0000;
          ready_r   <= 1'b1;
          mem_req_r <= 1'b0;
          valid_r   <= 1'b0;
          err_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready     = ready_r;
  assign bus.o_mem_req   = mem_req_r;
  assign bus.o_mem_wen   = mem_wen_r;
  assign bus.o_mem_addr  = mem_addr_r;
  assign bus.o_mem_wdata = mem_wdata_r;
  assign bus.o_mem_wmask = mem_wmask_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_rdata     = rdata_r;
  assign bus.o_err       = err_r;
  assign bus.o_err_code  = err_code_r;

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Scoreboard bench for the load/store unit, built with a 4-cycle timeout.
module tb_ysyx_24110006_lsu;

  logic clk;
  logic rst_n;

  ysyx_24110006_lsu_if bus_if();

  ysyx_24110006_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic        obs_err, obs_wen, obs_stable, obs_ready_low, obs_hold_ok;
  logic        obs_ready_after, obs_valid_after, obs_got;
  logic [1:0]  obs_code;
  logic [3:0]  obs_wmask;
  int          obs_lat, obs_req;

  // Issue one op, act as the memory (ack after ack_delay REQ cycles, -1 = never),
  // capture the response, hold RESP for hold cycles, then release it.
  task automatic run_op(input logic wen, input logic [2:0] func, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_delay,
                        input logic [31:0] mem_rdata, input int hold, input logic late_ack);
    obs_req = 0; obs_lat = 0; obs_got = 1'b0; obs_stable = 1'b1;
    obs_ready_low = 1'b1; obs_hold_ok = 1'b1;
    obs_addr = 32'h0; obs_wmask = 4'h0; obs_wdata = 32'h0; obs_wen = 1'b0;
    obs_rdata = 32'h0; obs_err = 1'b0; obs_code = 2'b00;
    bus_if.i_valid = 1'b1; bus_if.i_wen = wen; bus_if.i_func = func;
    bus_if.i_addr = addr; bus_if.i_wdata = wdata;
    @(posedge clk); #1;
    bus_if.i_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus_if.o_ready !== 1'b0) obs_ready_low = 1'b0;
      if (bus_if.o_valid === 1'b1) begin
        obs_lat = cyc; obs_got = 1'b1;
        obs_rdata = bus_if.o_rdata; obs_err = bus_if.o_err; obs_code = bus_if.o_err_code;
        break;
      end
      if (bus_if.o_mem_req === 1'b1) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_addr = bus_if.o_mem_addr; obs_wmask = bus_if.o_mem_wmask;
          obs_wdata = bus_if.o_mem_wdata; obs_wen = bus_if.o_mem_wen;
        end else if (bus_if.o_mem_addr !== obs_addr || bus_if.o_mem_wmask !== obs_wmask ||
                     bus_if.o_mem_wdata !== obs_wdata || bus_if.o_mem_wen !== obs_wen) begin
          obs_stable = 1'b0;
        end
        bus_if.i_mem_ack = (ack_delay >= 0) && (obs_req - 1 == ack_delay);
        bus_if.i_mem_rdata = mem_rdata;
      end else begin
        bus_if.i_mem_ack = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus_if.i_mem_ack = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus_if.i_ready = 1'b0;
      bus_if.i_mem_ack = late_ack;
      bus_if.i_mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      if (bus_if.o_valid !== 1'b1 || bus_if.o_ready !== 1'b0 || bus_if.o_mem_req !== 1'b0 ||
          bus_if.o_rdata !== obs_rdata || bus_if.o_err !== obs_err || bus_if.o_err_code !== obs_code)
        obs_hold_ok = 1'b0;
    end
    bus_if.i_mem_ack = 1'b0;
    bus_if.i_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.i_ready = 1'b0;
    obs_ready_after = bus_if.o_ready;
    obs_valid_after = bus_if.o_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.i_valid = 1'b0; bus_if.i_wen = 1'b0; bus_if.i_func = 3'b000;
    bus_if.i_addr = 32'h0; bus_if.i_wdata = 32'h0; bus_if.i_mem_ack = 1'b0;
    bus_if.i_mem_rdata = 32'h0; bus_if.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_if.o_ready !== 1'b1 || bus_if.o_mem_req !== 1'b0 || bus_if.o_valid !== 1'b0 ||
        bus_if.o_rdata !== 32'h0 || bus_if.o_err !== 1'b0 || bus_if.o_err_code !== 2'b00 ||
        bus_if.o_mem_wmask !== 4'h0 || bus_if.o_mem_addr !== 32'h0 || bus_if.o_mem_wen !== 1'b0)
      begin errors++; $display("FAIL reset_state: ready=%b req=%b valid=%b rdata=%h err=%b, want 1 0 0 0 0",
        bus_if.o_ready, bus_if.o_mem_req, bus_if.o_valid, bus_if.o_rdata, bus_if.o_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    exp_t e;
    exp_q.push_back('{32'hDEADBEEF, 1'b0, 2'b00});
    run_op(1'b0, 3'b010, 32'h8000_0010, 32'h0, 0, 32'hDEADBEEF, 0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== e.rdata || obs_err !== e.err || obs_code !== e.code)
      begin errors++; $display("FAIL lw_result: got rdata=%h err=%b code=%b, want %h %b %b",
        obs_rdata, obs_err, obs_code, e.rdata, e.err, e.code); end
    checks++;
    if (obs_addr !== 32'h8000_0010 || obs_wmask !== 4'b0000 || obs_wen !== 1'b0 || obs_req != 1)
      begin errors++; $display("FAIL lw_bus: got addr=%h wmask=%b wen=%b req=%0d, want 80000010 0000 0 1",
        obs_addr, obs_wmask, obs_wen, obs_req); end
    checks++;
    if (obs_lat != 2 || !obs_ready_low)
      begin errors++; $display("FAIL lw_latency: got %0d ready_low=%b, want 2 1", obs_lat, obs_ready_low); end
    checks++;
    if (obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0)
      begin errors++; $display("FAIL lw_release: got ready=%b valid=%b, want 1 0",
        obs_ready_after, obs_valid_after); end
  endtask

  task automatic test_loads();
    logic [2:0]  funcs [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] addrs [4] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0022, 32'h8000_0020};
    logic [31:0] words [4] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h1234_F00D};
    logic [31:0] wants [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_F00D};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{wants[i], 1'b0, 2'b00});
      run_op(1'b0, funcs[i], addrs[i], 32'h0, 1, words[i], 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (!obs_got || obs_rdata !== e.rdata || obs_err !== e.err || obs_code !== e.code)
        begin errors++; $display("FAIL load_%0d: got rdata=%h err=%b code=%b, want %h %b %b",
          i, obs_rdata, obs_err, obs_code, e.rdata, e.err, e.code); end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  funcs [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] addrs [3] = '{32'h8000_0102, 32'h8000_0201, 32'h8000_0300};
    logic [31:0] datas [3] = '{32'h1234_ABCD, 32'h7777_775A, 32'hCAFE_F00D};
    logic [31:0] mwant [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D};
    logic [31:0] awant [3] = '{32'h8000_0100, 32'h8000_0200, 32'h8000_0300};
    logic [3:0]  kwant [3] = '{4'b1100, 4'b0010, 4'b1111};
    int          delay [3] = '{3, 0, 1};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{32'h0, 1'b0, 2'b00});
      run_op(1'b1, funcs[i], addrs[i], datas[i], delay[i], 32'hFFFF_FFFF, 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (!obs_got || obs_rdata !== e.rdata || obs_err !== e.err || obs_code !== e.code)
        begin errors++; $display("FAIL store_%0d_result: got rdata=%h err=%b code=%b, want %h %b %b",
          i, obs_rdata, obs_err, obs_code, e.rdata, e.err, e.code); end
      checks++;
      if (obs_addr !== awant[i] || obs_wmask !== kwant[i] || obs_wdata !== mwant[i] ||
          obs_wen !== 1'b1 || !obs_stable || obs_req != delay[i] + 1)
        begin errors++; $display("FAIL store_%0d_bus: got addr=%h wmask=%b wdata=%h stable=%b req=%0d, want %h %b %h 1 %0d",
          i, obs_addr, obs_wmask, obs_wdata, obs_stable, obs_req, awant[i], kwant[i], mwant[i], delay[i] + 1); end
    end
  endtask

  task automatic test_errors();
    logic        wens  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  funcs [3] = '{3'b010, 3'b011, 3'b110};
    logic [31:0] addrs [3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0000};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{32'h0, 1'b1, 2'b01});
      run_op(wens[i], funcs[i], addrs[i], 32'h1111_1111, 0, 32'h0, 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (!obs_got || obs_rdata !== e.rdata || obs_err !== e.err || obs_code !== e.code ||
          obs_req != 0 || obs_lat != 1)
        begin errors++; $display("FAIL error_%0d: got rdata=%h err=%b code=%b req=%0d lat=%0d, want %h %b %b 0 1",
          i, obs_rdata, obs_err, obs_code, obs_req, obs_lat, e.rdata, e.err, e.code); end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    exp_q.push_back('{32'h0, 1'b1, 2'b10});
    run_op(1'b0, 3'b010, 32'h8000_0040, 32'h0, -1, 32'h5555_5555, 2, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== e.rdata || obs_err !== e.err || obs_code !== e.code)
      begin errors++; $display("FAIL timeout_result: got rdata=%h err=%b code=%b, want %h %b %b",
        obs_rdata, obs_err, obs_code, e.rdata, e.err, e.code); end
    checks++;
    if (obs_req != 4 || obs_lat != 5)
      begin errors++; $display("FAIL timeout_cycles: got req=%0d lat=%0d, want 4 5", obs_req, obs_lat); end
    checks++;
    if (!obs_hold_ok)
      begin errors++; $display("FAIL timeout_late_ack: got response changed=1, want 0"); end
  endtask

  task automatic test_hold_and_reset();
    exp_t e;
    logic seen_valid;
    exp_q.push_back('{32'h0BAD_F00D, 1'b0, 2'b00});
    run_op(1'b0, 3'b010, 32'h8000_0080, 32'h0, 0, 32'h0BAD_F00D, 5, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== e.rdata || obs_err !== e.err || !obs_hold_ok || obs_ready_after !== 1'b1)
      begin errors++; $display("FAIL hold_resp: got rdata=%h hold_ok=%b ready_after=%b, want %h 1 1",
        obs_rdata, obs_hold_ok, obs_ready_after, e.rdata); end
    bus_if.i_valid = 1'b1; bus_if.i_wen = 1'b0; bus_if.i_func = 3'b010; bus_if.i_addr = 32'h8000_0090;
    @(posedge clk); #1;
    bus_if.i_valid = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (bus_if.o_mem_req !== 1'b1)
      begin errors++; $display("FAIL reset_pre_req: got req=%b, want 1", bus_if.o_mem_req); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.o_mem_req !== 1'b0 || bus_if.o_ready !== 1'b1 || bus_if.o_valid !== 1'b0)
      begin errors++; $display("FAIL reset_async: got req=%b ready=%b valid=%b, want 0 1 0",
        bus_if.o_mem_req, bus_if.o_ready, bus_if.o_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus_if.i_mem_ack = (c == 2);
      @(posedge clk); #1;
      if (bus_if.o_valid !== 1'b0 || bus_if.o_ready !== 1'b1 || bus_if.o_mem_req !== 1'b0) seen_valid = 1'b1;
    end
    bus_if.i_mem_ack = 1'b0;
    checks++;
    if (seen_valid)
      begin errors++; $display("FAIL reset_abandon: got activity after reset=1, want 0"); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_hold_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
